// File: rtl/gen1_tx_scheduler.sv
// ---------------------------------------------------------------------------
// gen1_tx_scheduler
//
// Gen1/Gen2 transmit sequencer sitting in front of the per-lane 8b/10b
// scrambler input. Three symbol sources share one 32-bit symbol stream with
// per-byte K flags:
//   * link-layer packet data (data_*)
//   * LTSSM ordered sets such as TS1/TS2/EIOS (os_*)
//   * periodic SKP ordered sets generated internally
// Gaps are filled with logical idle (D0.0). Sources are only switched at
// packet / ordered-set boundaries, so the scrambler never sees an
// interleaved stream.
//
// Parameters:
//   SKP_INTERVAL     symbol times between SKP OS schedules
//   MAX_PENDING_SKP  saturation limit of deferred SKP requests
//   SKP_COUNT        SKP symbols following COM in each SKP OS
//
// Ports:
//   clk_i          symbol-rate clock
//   rst_i          asynchronous active-low reset
//   pipe_width_i   active bytes x 8 (8/16/32, anything else means 32)
//   out_ready_i    PHY accepts the output beat this cycle
//   data_i/data_k_i/data_valid_i/data_last_i/data_ready_o
//                  link-layer beat channel, byte 0 = [7:0] sent first
//   os_i/os_k_i/os_valid_i/os_last_i/os_ready_o
//                  ordered-set beat channel
//   skp_block_i    suppress SKP scheduling (compliance, Detect, elec. idle)
//   data_o/data_k_o/data_valid_o
//                  registered symbol beat towards the scrambler
//   skp_count_o    number of SKP OS inserted (statistics build only)
//
// Build option:
//   GEN1_TX_SKP_STATS_EN  when defined, skp_count_o counts every inserted
//                         SKP OS (wrapping at 16 bits); otherwise it is tied
//                         to zero and no counter exists.
// ---------------------------------------------------------------------------
module gen1_tx_scheduler #(
    parameter int SKP_INTERVAL    = 1180,
    parameter int MAX_PENDING_SKP = 2,
    parameter int SKP_COUNT       = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  pipe_width_i,
    input  logic        out_ready_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  data_k_i,
    input  logic        data_valid_i,
    input  logic        data_last_i,
    output logic        data_ready_o,
    input  logic [31:0] os_i,
    input  logic [3:0]  os_k_i,
    input  logic        os_valid_i,
    input  logic        os_last_i,
    output logic        os_ready_o,
    input  logic        skp_block_i,
    output logic [31:0] data_o,
    output logic [3:0]  data_k_o,
    output logic        data_valid_o,
    output logic [15:0] skp_count_o
);

    localparam int CNT_W    = $clog2(SKP_INTERVAL + 4) + 1;
    localparam int PEND_W   = $clog2(MAX_PENDING_SKP + 1) + 1;
    localparam int SKP_SYMS = SKP_COUNT + 1;
    localparam int BEAT_W   = $clog2(SKP_SYMS + 1) + 1;

    localparam logic [7:0]       SYM_COM    = 8'hBC;
    localparam logic [7:0]       SYM_SKP    = 8'h1C;
    localparam logic [CNT_W-1:0] INTERVAL_C = CNT_W'(SKP_INTERVAL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKP,
        ST_OS,
        ST_DATA
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_SKP,
        GNT_OS,
        GNT_DATA
    } grant_t;

    state_t              state_q;
    state_t              state_d;
    grant_t              grant;
    logic [2:0]          width_q;
    logic [2:0]          width_eff;
    logic [CNT_W-1:0]    interval_q;
    logic [CNT_W-1:0]    interval_d;
    logic [CNT_W-1:0]    interval_sum;
    logic                skp_due;
    logic [PEND_W-1:0]   pending_q;
    logic [PEND_W-1:0]   pending_d;
    logic [BEAT_W-1:0]   skp_beat_q;
    logic [BEAT_W-1:0]   skp_beat_d;
    logic [31:0]         beat_data;
    logic [3:0]          beat_k;
    logic                skp_final;

    // Bytes per beat from the PIPE width code; unsupported codes mean 4 bytes.
    function automatic logic [2:0] decode_width(input logic [5:0] pw);
        case (pw)
            6'd8:    return 3'd1;
            6'd16:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // The width is sampled live while idle and frozen for the rest of a
    // packet / ordered set, so a width change never splits a transfer.
    assign width_eff = (state_q == ST_IDLE) ? decode_width(pipe_width_i) : width_q;

    // Source grant: in IDLE the priority is SKP > OS > DATA; in any other
    // state the owner of the current transfer keeps the grant until its
    // boundary. Ready is only offered in IDLE when the source is valid, so a
    // source dropping valid before acceptance loses nothing.
    always_comb begin
        grant = GNT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    grant = GNT_SKP;
                end else if (os_valid_i) begin
                    grant = GNT_OS;
                end else if (data_valid_i) begin
                    grant = GNT_DATA;
                end
            end
            ST_SKP:  grant = GNT_SKP;
            ST_OS:   grant = GNT_OS;
            ST_DATA: grant = GNT_DATA;
            default: grant = GNT_NONE;
        endcase
    end

    assign data_ready_o = out_ready_i && (grant == GNT_DATA);
    assign os_ready_o   = out_ready_i && (grant == GNT_OS);

    // Beat construction and next state. A SKP OS is the symbol string
    // COM, SKP x SKP_COUNT cut into width-sized beats; the beat index says
    // which slice goes out now. The first SKP beat is produced directly from
    // IDLE, so a full-width SKP OS never visits the SKP state at all.
    // Underrun in DATA emits an idle beat but keeps the packet's grant.
    always_comb begin
        int w;
        int beat;
        int sym;
        beat_data  = '0;
        beat_k     = '0;
        state_d    = state_q;
        skp_beat_d = skp_beat_q;
        skp_final  = 1'b0;
        w          = int'(width_eff);
        beat       = (state_q == ST_SKP) ? int'(skp_beat_q) : 0;
        sym        = 0;
        case (grant)
            GNT_SKP: begin
                for (int b = 0; b < 4; b++) begin
                    sym = beat * w + b;
                    if (b < w && sym < SKP_SYMS) begin
                        beat_data[8*b +: 8] = (sym == 0) ? SYM_COM : SYM_SKP;
                        beat_k[b]           = 1'b1;
                    end
                end
                if ((beat + 1) * w >= SKP_SYMS) begin
                    skp_final  = 1'b1;
                    state_d    = ST_IDLE;
                    skp_beat_d = '0;
                end else begin
                    state_d    = ST_SKP;
                    skp_beat_d = BEAT_W'(beat + 1);
                end
            end
            GNT_OS: begin
                state_d = ST_OS;
                if (os_valid_i) begin
                    beat_data = os_i;
                    beat_k    = os_k_i;
                    if (os_last_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            GNT_DATA: begin
                state_d = ST_DATA;
                if (data_valid_i) begin
                    beat_data = data_i;
                    beat_k    = data_k_i;
                    if (data_last_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            if (b >= w) begin
                beat_data[8*b +: 8] = 8'h00;
                beat_k[b]           = 1'b0;
            end
        end
    end

    // SKP scheduling. The interval accumulator keeps the remainder so the
    // long-term SKP rate is exact for every width. Pending requests saturate;
    // a request arriving on the same beat that finishes a SKP OS cancels out
    // against it. While blocked, the accumulator freezes and requests vanish.
    always_comb begin
        int p;
        interval_sum = interval_q + CNT_W'(width_eff);
        skp_due      = (interval_sum >= INTERVAL_C);
        interval_d   = skp_due ? (interval_sum - INTERVAL_C) : interval_sum;
        p = int'(pending_q) + (skp_due ? 1 : 0)
            - ((skp_final && (pending_q != '0)) ? 1 : 0);
        if (p > MAX_PENDING_SKP) begin
            p = MAX_PENDING_SKP;
        end
        if (p < 0) begin
            p = 0;
        end
        pending_d = PEND_W'(p);
        if (skp_block_i) begin
            interval_d = interval_q;
            pending_d  = '0;
        end
    end

    // Control state only moves when the PHY takes a beat; with out_ready_i
    // low the whole scheduler stalls, including SKP accounting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            width_q    <= 3'd4;
            interval_q <= '0;
            pending_q  <= '0;
            skp_beat_q <= '0;
        end else if (out_ready_i) begin
            state_q    <= state_d;
            width_q    <= width_eff;
            interval_q <= interval_d;
            pending_q  <= pending_d;
            skp_beat_q <= skp_beat_d;
        end
    end

    // Output register: one cycle from source acceptance to data_o. Once out
    // of reset every accepted cycle carries a valid beat (idle if nothing
    // else), and a stalled cycle simply holds the previous beat.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o       <= '0;
            data_k_o     <= '0;
            data_valid_o <= 1'b0;
        end else if (out_ready_i) begin
            data_o       <= beat_data;
            data_k_o     <= beat_k;
            data_valid_o <= 1'b1;
        end
    end

`ifdef GEN1_TX_SKP_STATS_EN
    logic [15:0] skp_count_q;

    // Counts completed SKP ordered sets; wraps silently at 16 bits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            skp_count_q <= '0;
        end else if (out_ready_i && skp_final) begin
            skp_count_q <= skp_count_q + 16'd1;
        end
    end

    assign skp_count_o = skp_count_q;
`else
    assign skp_count_o = '0;
`endif

endmodule

// File: doc/gen1_tx_scheduler.md
Name: gen1_tx_scheduler

Overview:
- Gen1/Gen2 transmit sequencer upstream of the per-lane 8b/10b scrambler input.
- Arbitrates three symbol sources onto one 32-bit symbol stream with per-byte K flags: link-layer packet data, LTSSM ordered sets (TS1/TS2/EIOS etc.) and periodic SKP ordered sets.
- Fills gaps with logical idle (D0.0). Switches sources only at packet/ordered-set boundaries, so the scrambler never sees an interleaved stream.

Parameters:
- SKP_INTERVAL, 1180, symbol times between SKP OS schedules.
- MAX_PENDING_SKP, 2, saturation limit of deferred SKP requests.
- SKP_COUNT, 3, SKP symbols following COM in each SKP OS.

Ports:
- clk_i  in  1  symbol-rate clock
- rst_i  in  1  asynchronous active-low reset
- pipe_width_i  in  6  active bytes×8 (8/16/32); other values treated as 32
- out_ready_i  in  1  PHY accepts the output beat this cycle
- data_i  in  32  link-layer symbols, byte 0 = [7:0] transmitted first
- data_k_i  in  4  per-byte K flags for data_i
- data_valid_i  in  1  link-layer beat valid
- data_last_i  in  1  final beat of packet
- data_ready_o  out  1  link-layer beat accepted
- os_i  in  32  ordered-set symbols
- os_k_i  in  4  K flags for os_i
- os_valid_i  in  1  OS beat valid
- os_last_i  in  1  final beat of ordered set
- os_ready_o  out  1  OS beat accepted
- skp_block_i  in  1  suppress SKP scheduling (compliance, Detect, electrical idle)
- data_o  out  32  symbols to scrambler
- data_k_o  out  4  K flags to scrambler
- data_valid_o  out  1  output beat valid
- skp_count_o  out  16  SKP OS inserted (optional feature)

Behaviour:
- Reset (rst_i=0, async): data_o=0, data_k_o=0, data_valid_o=0, data_ready_o=0, os_ready_o=0, skp_count_o=0, interval counter=0, pending=0, state=IDLE.
- Active width W = pipe_width_i>>3 bytes. Latched in IDLE only; changes mid-packet/OS are ignored until the next return to IDLE. Bytes >= W on data_o are driven 0 with K=0.
- Output register advances only when out_ready_i=1; otherwise all outputs and state hold. Latency is 1 cycle from source acceptance to data_o. After reset, data_valid_o=1 on every cycle with out_ready_i=1.
- data_ready_o = out_ready_i && grant==DATA. os_ready_o = out_ready_i && grant==OS. Both are combinational from state and out_ready_i.
- Interval counter: adds W on each advancing cycle. When sum >= SKP_INTERVAL, subtract SKP_INTERVAL (remainder kept) and increment pending (saturating at MAX_PENDING_SKP). Counter frozen and pending cleared while skp_block_i=1.
- States:
  - IDLE: when advancing, select by priority pending>0 -> SKP; os_valid_i -> OS; data_valid_i -> DATA; else emit one idle beat (W bytes 0x00, K=0).
  - SKP: emit COM (0xBC, K) then SKP_COUNT SKP (0x1C, K), packed W bytes per beat in transmit order (W=4: 1 beat; W=2: 2 beats; W=1: 4 beats). On the final beat, decrement pending (same-cycle increment nets 0) and go to IDLE.
  - OS: pass os_i/os_k_i through until an accepted beat with os_last_i=1, then IDLE.
  - DATA: pass data_i/data_k_i through. Go to IDLE on an accepted beat with data_last_i=1. If data_valid_i=0 mid-packet, emit an idle beat and remain in DATA (underrun tolerated, no source switch).
- Boundary checks from IDLE: pending, os_valid_i and data_valid_i all set -> SKP first, then OS, then DATA. Pending reaching saturation inside a long packet does not preempt; excess requests are dropped.
- Source valid deasserted after a grant in IDLE: grant is re-evaluated next IDLE cycle (no beat lost, since ready was only asserted with valid).
- Single-beat packet (valid && last in IDLE): passes through, then IDLE on the next cycle.

Optional Feature:
- GEN1_TX_SKP_STATS_EN defined: skp_count_o increments (wrapping at 16 bits) on the final beat of each SKP OS. Reset to 0.
- Undefined: skp_count_o tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, all valids 0, out_ready_i=1, W=4 -> data_o=0x00000000, K=0, valid=1 every cycle. First SKP beat data_o=0x1C1C1CBC, K=0xF after 295 beats (1180/4).
- W=1, force pending -> 4 consecutive beats 0xBC,0x1C,0x1C,0x1C with data_k_o[0]=1, then idle.
- 10-beat DATA packet active when the interval expires -> packet completes unbroken, SKP OS immediately follows beat 10, pending returns to 0.
- os_valid_i and data_valid_i asserted together in IDLE with pending=0 -> OS packet first, data_ready_o stays 0 until os_last_i accepted.
- out_ready_i low for 3 cycles mid-packet -> data_o stable, no ready asserted, no data lost; interval counter unchanged.
- skp_block_i=1 for 3000 symbols -> no SKP emitted, pending=0. GEN1_TX_SKP_STATS_EN build: skp_count_o increments by 1 per inserted SKP OS.
